// File: rtl/alu3_arbiter.sv
// alu3_arbiter: round-robin front end that shares one external 3-bit ALU
// among NREQ requesters. One operation is in flight at a time: the winner's
// operands are registered onto the ALU inputs, the result is captured one
// cycle later, and it is returned on a single response channel together
// with the requester index. Illegal opcodes skip the ALU and return an error.
module alu3_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   ReqValid,
  input  logic [3*NREQ-1:0] ReqOp,
  input  logic [3*NREQ-1:0] ReqA,
  input  logic [3*NREQ-1:0] ReqB,
  output logic [NREQ-1:0]   ReqReady,
  output logic [2:0]        AluIn1,
  output logic [2:0]        AluIn2,
  output logic [2:0]        AluSel,
  input  logic [3:0]        AluOut,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [IDW-1:0]    RspId,
  output logic [3:0]        RspData,
  output logic              RspErr,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic           found;
  logic [IDW-1:0] win_id;
  logic [2:0]     win_op;
  logic [2:0]     win_a;
  logic [2:0]     win_b;
  logic [IDW-1:0] next_ptr;
  logic           win_legal;

  // Round-robin search: first valid requester at or above the pointer, with wrap.
  always_comb begin
    logic [IDW:0] sum;
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      if (!found && ReqValid[sum[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = sum[IDW-1:0];
      end
    end
  end

  // Pick the winner's opcode and operand slices out of the packed buses.
  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_op = ReqOp[3*i +: 3];
        win_a  = ReqA[3*i +: 3];
        win_b  = ReqB[3*i +: 3];
      end
    end
  end

  // Accept strobe is only offered while idle, and only to the current winner.
  always_comb begin
    ReqReady = '0;
    if (state == IDLE && found) begin
      ReqReady[win_id] = 1'b1;
    end
  end

  // Pointer moves just past the requester that was served; NREQ need not be a power of two.
  always_comb begin
    next_ptr = RspId + IDW'(1);
    if (RspId == IDW'(NREQ - 1)) begin
      next_ptr = '0;
    end
  end

  assign win_legal = (win_op <= 3'd4);

  // Sequencer: accept in IDLE, let the ALU settle in EXEC, hold the response in RESP.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      ptr      <= '0;
      AluIn1   <= '0;
      AluIn2   <= '0;
      AluSel   <= '0;
      RspValid <= 1'b0;
      RspId    <= '0;
      RspData  <= '0;
      RspErr   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            RspId <= win_id;
            Busy  <= 1'b1;
            if (win_legal) begin
              AluIn1 <= win_a;
              AluIn2 <= win_b;
              AluSel <= win_op;
              state  <= EXEC;
            end else begin
              RspData  <= 4'd0;
              RspErr   <= 1'b1;
              RspValid <= 1'b1;
              state    <= RESP;
            end
          end
        end
        EXEC: begin
          RspData  <= AluOut;
          RspErr   <= 1'b0;
          RspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            ptr      <= next_ptr;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          RspValid <= 1'b0;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu3_arbiter.sv
// tb_alu3_arbiter: self-checking bench for alu3_arbiter. Supplies the shared
// ALU itself, runs a table of directed transactions, reset and throughput
// sequences, then random traffic checked against a simple arbitration model.
module tb_alu3_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NREQ-1:0]   ReqValid;
  logic [3*NREQ-1:0] ReqOp;
  logic [3*NREQ-1:0] ReqA;
  logic [3*NREQ-1:0] ReqB;
  logic [NREQ-1:0]   ReqReady;
  logic [2:0]        AluIn1;
  logic [2:0]        AluIn2;
  logic [2:0]        AluSel;
  logic [3:0]        AluOut;
  logic              RspValid;
  logic              RspReady;
  logic [IDW-1:0]    RspId;
  logic [3:0]        RspData;
  logic              RspErr;
  logic              Busy;
  logic [21:0]       all_outs;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;
  logic [2:0] last_sel = '0;
  logic [2:0] last_in1 = '0;
  logic [2:0] last_in2 = '0;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    int         exp_id;
    logic [3:0] exp_data;
    logic       exp_err;
    int         hold;
  } vec_t;

  vec_t vecs[9];

  alu3_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
    .ReqReady(ReqReady),
    .AluIn1(AluIn1), .AluIn2(AluIn2), .AluSel(AluSel), .AluOut(AluOut),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .RspData(RspData), .RspErr(RspErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Behavioural ALU written with plain integer arithmetic.
  function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    r = ia & ib;
      3'd1:    r = ia | ib;
      3'd2:    r = ia ^ ib;
      3'd3:    r = (ia + ib) % 16;
      3'd4:    r = (ia - ib + 16) % 16;
      default: r = 0;
    endcase
    return 4'(r);
  endfunction

  // Reference arbitration: scan from the pointer with wrap-around.
  function automatic int pick_winner(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  assign AluOut   = alu_model(AluSel, AluIn1, AluIn2);
  assign all_outs = {ReqReady, AluIn1, AluIn2, AluSel, RspValid, RspId, RspData, RspErr, Busy};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  task automatic clear_reqs();
    ReqValid = '0;
    ReqOp    = '0;
    ReqA     = '0;
    ReqB     = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    clear_reqs();
    RspReady = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    model_ptr = 0;
    last_sel  = '0;
    last_in1  = '0;
    last_in2  = '0;
  endtask

  // One complete transaction: offer requests, check the grant, latency, response and release.
  task automatic apply_stimulus(input logic [3:0] mask, input logic [11:0] ops, input logic [11:0] as,
                                input logic [11:0] bs, input int exp_id, input logic [3:0] exp_data,
                                input logic exp_err, input int hold);
    int waited;
    int lat;
    logic [2:0] w_op, w_a, w_b;
    logic [1:0] eid;
    eid  = 2'(exp_id);
    w_op = ops[3*exp_id +: 3];
    w_a  = as[3*exp_id +: 3];
    w_b  = bs[3*exp_id +: 3];
    @(negedge Clk);
    ReqValid = mask;
    ReqOp    = ops;
    ReqA     = as;
    ReqB     = bs;
    RspReady = 1'b0;
    #1;
    waited = 0;
    while (ReqReady == '0 && waited < 10) begin
      @(negedge Clk);
      #1;
      waited++;
    end
    if (ReqReady == '0) begin
      fail_now("grant_timeout");
      clear_reqs();
      return;
    end
    check_output("grant", 32'(ReqReady), 32'(4'b0001 << exp_id));
    @(posedge Clk);
    #1;
    ReqValid[exp_id] = 1'b0;
    check_output("busy_after_accept", 32'(Busy), 32'd1);
    lat = 1;
    while (!RspValid && lat < 10) begin
      check_output("no_grant_while_busy", 32'(ReqReady), 32'd0);
      @(posedge Clk);
      #1;
      lat++;
    end
    if (!RspValid) begin
      fail_now("rsp_timeout");
      clear_reqs();
      return;
    end
    check_output("latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
    check_output("rsp", 32'({RspId, RspData, RspErr}), 32'({eid, exp_data, exp_err}));
    check_output("alu_regs", 32'({AluSel, AluIn1, AluIn2}),
                 exp_err ? 32'({last_sel, last_in1, last_in2}) : 32'({w_op, w_a, w_b}));
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk);
      #1;
      check_output("rsp_hold", 32'({RspValid, RspId, RspData, RspErr, ReqReady}),
                   32'({1'b1, eid, exp_data, exp_err, 4'b0000}));
    end
    @(negedge Clk);
    RspReady = 1'b1;
    @(posedge Clk);
    #1;
    RspReady = 1'b0;
    check_output("rsp_release", 32'({RspValid, Busy}), 32'd0);
    clear_reqs();
    model_ptr = (exp_id + 1) % NREQ;
    if (!exp_err) begin
      last_sel = w_op;
      last_in1 = w_a;
      last_in2 = w_b;
    end
  endtask

  // Build packed request buses: the expected winner carries the real operation, others carry decoys.
  task automatic run_vector(input vec_t v);
    logic [11:0] ops, as, bs;
    for (int i = 0; i < NREQ; i++) begin
      if (i == v.exp_id) begin
        ops[3*i +: 3] = v.op;
        as[3*i +: 3]  = v.a;
        bs[3*i +: 3]  = v.b;
      end else begin
        ops[3*i +: 3] = 3'd2;
        as[3*i +: 3]  = ~v.a;
        bs[3*i +: 3]  = 3'(i);
      end
    end
    apply_stimulus(v.mask, ops, as, bs, v.exp_id, v.exp_data, v.exp_err, v.hold);
  endtask

  initial begin
    int grants;
    int last_grant_cyc;
    int last_grant_id;
    int g;
    logic [3:0]  mask;
    logic [11:0] ops, as, bs;
    logic [2:0]  op_w;
    int          id;
    logic        err;
    logic [3:0]  dat;

    // Directed vectors, pointer starting at 0 after reset.
    vecs[0] = '{4'b0100, 3'd3, 3'd7, 3'd7, 2, 4'hE, 1'b0, 0};
    vecs[1] = '{4'b0001, 3'd4, 3'd2, 3'd5, 0, 4'hD, 1'b0, 3};
    vecs[2] = '{4'b0010, 3'd6, 3'd1, 3'd1, 1, 4'h0, 1'b1, 0};
    vecs[3] = '{4'b1011, 3'd2, 3'd5, 3'd3, 3, 4'h6, 1'b0, 0};
    vecs[4] = '{4'b1010, 3'd1, 3'd4, 3'd2, 1, 4'h6, 1'b0, 1};
    vecs[5] = '{4'b0011, 3'd0, 3'd6, 3'd3, 0, 4'h2, 1'b0, 0};
    vecs[6] = '{4'b1111, 3'd7, 3'd3, 3'd3, 1, 4'h0, 1'b1, 2};
    vecs[7] = '{4'b0101, 3'd4, 3'd0, 3'd1, 2, 4'hF, 1'b0, 0};
    vecs[8] = '{4'b1001, 3'd3, 3'd1, 3'd2, 3, 4'h3, 1'b0, 1};

    Rst = 1'b1;
    clear_reqs();
    RspReady = 1'b0;
    #1;
    check_output("reset_outputs", 32'(all_outs), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      check_output("idle_after_reset", 32'(all_outs), 32'd0);
    end

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      run_vector(vecs[i]);
    end

    $display("[TB] reset during EXEC");
    run_vector('{4'b0010, 3'd0, 3'd7, 3'd7, 1, 4'h7, 1'b0, 0});
    @(negedge Clk);
    ReqValid = 4'b1000;
    ReqOp    = 12'(3'd1) << 9;
    ReqA     = 12'(3'd5) << 9;
    ReqB     = 12'(3'd2) << 9;
    #1;
    check_output("grant_before_reset", 32'(ReqReady), 32'h8);
    @(posedge Clk);
    #2;
    clear_reqs();
    Rst = 1'b1;
    #1;
    check_output("async_reset_outputs", 32'(all_outs), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      check_output("no_rsp_after_reset", 32'({RspValid, Busy}), 32'd0);
    end
    model_ptr = 0;
    last_sel  = '0;
    last_in1  = '0;
    last_in2  = '0;
    run_vector('{4'b1111, 3'd1, 3'd5, 3'd2, pick_winner(4'b1111, 0), 4'h7, 1'b0, 0});

    $display("[TB] back-to-back throughput");
    @(negedge Clk);
    Rst = 1'b1;
    ReqValid = 4'b1111;
    ReqOp    = '0;
    ReqA     = {4{3'd7}};
    ReqB     = {4{3'd3}};
    RspReady = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_ptr = 0;
    grants = 0;
    last_grant_cyc = -1;
    last_grant_id  = -1;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (ReqReady != '0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (ReqReady[i]) g = i;
        check_output("rr_order", 32'(g), 32'(pick_winner(4'b1111, model_ptr)));
        if (last_grant_cyc >= 0) check_output("rr_spacing", 32'(c - last_grant_cyc), 32'd3);
        last_grant_cyc = c;
        last_grant_id  = g;
        model_ptr = (g + 1) % NREQ;
        grants++;
      end
      if (RspValid) begin
        check_output("rr_rsp", 32'({RspId, RspData, RspErr}), 32'({2'(last_grant_id), 4'h3, 1'b0}));
      end
      @(negedge Clk);
      #1;
    end
    check_output("rr_grant_count", 32'(grants), 32'd6);

    $display("[TB] random traffic");
    do_reset();
    for (int r = 0; r < 40; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        ops[3*i +: 3] = 3'($urandom_range(0, 7));
        as[3*i +: 3]  = 3'($urandom_range(0, 7));
        bs[3*i +: 3]  = 3'($urandom_range(0, 7));
      end
      id   = pick_winner(mask, model_ptr);
      op_w = ops[3*id +: 3];
      err  = (op_w > 3'd4);
      dat  = err ? 4'h0 : alu_model(op_w, as[3*id +: 3], bs[3*id +: 3]);
      apply_stimulus(mask, ops, as, bs, id, dat, err, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
